ptp_bridge_seg_len_guard: RTL and testbench

- Parametrised segment-stream conditioner on the bridge datapath, placed between the ingress width adjuster and the TCAM key extractor.
- Zeroes the invalid bytes of every segment, generalising the fixed 64-byte bytes-valid mask to any DATA_BYTES.
- Tracks packet length and truncates oversize packets. Detects framing errors (missing SOP/EOP).
- Keeps saturating statistics counters readable by the CSR block.

---
 rtl/ptp_bridge_pkg.sv | 38 +++
 rtl/ptp_bridge_skid_buf.sv | 63 ++++++
 rtl/ptp_bridge_seg_len_guard.sv | 193 +++++++++++++++++++
 tb/tb_ptp_bridge_seg_len_guard.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_bridge_pkg.sv
// Shared types and helpers for the bridge datapath.
package ptp_bridge_pkg;

    localparam int unsigned MAX_PKT_SIZE  = 9216;
    localparam int unsigned MAX_SEG_BYTES = 128;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] bytesvld;  // valid bytes on an eop beat; 0 means a full segment
        logic [7:0] src_port;
        logic [7:0] dst_port;
    } segment_info_s;

    localparam int unsigned SEGMENT_INFO_WIDTH = $bits(segment_info_s);
    // Position of eop inside a flattened segment_info_s (sop is the MSB).
    localparam int unsigned SEG_EOP_BIT = SEGMENT_INFO_WIDTH - 2;

    typedef enum logic [1:0] {LG_IDLE, LG_IN_PKT, LG_DISCARD} lg_state_e;

    // Bytes a beat really carries: full segment unless it is an eop beat with a sane bytesvld.
    function automatic logic [7:0] fn_eff_bytes(input logic [7:0] bytesvld, input logic eop,
                                                input int unsigned data_bytes);
        if (!eop || bytesvld == 8'd0 || 32'(bytesvld) > data_bytes) begin
            return 8'(data_bytes);
        end
        return bytesvld;
    endfunction

    // Bit i set when byte i (byte 0 = first on the wire) is below n and inside the segment.
    function automatic logic [MAX_SEG_BYTES-1:0] fn_mask_bytesvld_n(input logic [7:0] n,
                                                                    input int unsigned data_bytes);
        logic [MAX_SEG_BYTES-1:0] ones;
        ones = '1;
        return ~(ones << n) & ~(ones << data_bytes);
    endfunction

endpackage

// File: rtl/ptp_bridge_skid_buf.sv
// Two-entry buffer whose input ready is a flop, so it never depends on m_ready_i
// combinationally while still sustaining one transfer per cycle.
module ptp_bridge_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = s_valid_i && ready_q;
    assign pop       = m_valid_o && m_ready_i;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign s_ready_o = ready_q;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and the registered ready flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/ptp_bridge_seg_len_guard.sv
// Segment-stream conditioner: masks invalid bytes, truncates oversize packets,
// drops unframed data and keeps saturating statistics.
module ptp_bridge_seg_len_guard
    import ptp_bridge_pkg::*;
#(
    parameter int unsigned DATA_BYTES    = 64,
    parameter int unsigned MAX_PKT_BYTES = MAX_PKT_SIZE,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [DATA_BYTES*8-1:0]       s_tdata,
    input  logic [SEGMENT_INFO_WIDTH-1:0] s_tuser,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_BYTES*8-1:0]       m_tdata,
    output logic [SEGMENT_INFO_WIDTH-1:0] m_tuser,
    output logic                          m_terr,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          pkt_cnt,
    output logic [CNT_WIDTH-1:0]          oversize_cnt,
    output logic [CNT_WIDTH-1:0]          framing_err_cnt
);

    localparam int unsigned DW        = DATA_BYTES * 8;
    localparam int unsigned LEN_W     = $clog2(MAX_PKT_BYTES + DATA_BYTES) + 1;
    localparam int unsigned PAYLOAD_W = 1 + SEGMENT_INFO_WIDTH + DW;
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PKT_BYTES);

    lg_state_e                state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [CNT_WIDTH-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]     over_cnt_q, over_cnt_d;
    logic [CNT_WIDTH-1:0]     ferr_cnt_q, ferr_cnt_d;

    segment_info_s            in_info;
    segment_info_s            out_info;
    logic                     buf_ready;
    logic                     in_hs;
    logic [7:0]               eb;
    logic [LEN_W-1:0]         base_len;
    logic [LEN_W-1:0]         new_len;
    logic [LEN_W-1:0]         trim;
    logic                     over;
    logic                     emit;
    logic                     ferr_evt;
    logic                     over_evt;
    logic                     pkt_evt;
    logic [7:0]               keep_n;
    logic [MAX_SEG_BYTES-1:0] byte_mask;
    logic [DW-1:0]            out_data;
    logic [PAYLOAD_W-1:0]     buf_out;
    logic                     unused_mask;

    assign in_info  = s_tuser;
    assign in_hs    = s_tvalid && buf_ready;
    assign s_tready = buf_ready;

    assign eb       = fn_eff_bytes(in_info.bytesvld, in_info.eop, DATA_BYTES);
    // A sop always restarts the count, including one that arrives mid-packet.
    assign base_len = (state_q == LG_IN_PKT && !in_info.sop) ? len_q : '0;
    assign new_len  = base_len + LEN_W'(eb);
    assign over     = (new_len > MaxLen);
    assign trim     = MaxLen - base_len;

    // FSM state and length accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LG_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Next state: emitted beats track length, dropped beats resync on eop.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        if (in_hs) begin
            if (emit) begin
                len_d = new_len;
                if (in_info.eop) begin
                    state_d = LG_IDLE;
                end else if (over) begin
                    state_d = LG_DISCARD;
                end else begin
                    state_d = LG_IN_PKT;
                end
            end else begin
                state_d = in_info.eop ? LG_IDLE : LG_DISCARD;
            end
        end
    end

    // FSM outputs: which beats go downstream, how they are rewritten, which events count.
    always_comb begin
        emit     = 1'b0;
        ferr_evt = 1'b0;
        over_evt = 1'b0;
        out_info = in_info;
        keep_n   = eb;
        if (in_hs) begin
            case (state_q)
                LG_IN_PKT: begin
                    emit     = 1'b1;
                    ferr_evt = in_info.sop;
                end
                LG_DISCARD: begin
                    emit     = in_info.sop;
                    ferr_evt = in_info.sop;
                end
                default: begin
                    emit     = in_info.sop;
                    ferr_evt = !in_info.sop;
                end
            endcase
        end
        if (emit && over) begin
            over_evt          = 1'b1;
            out_info.eop      = 1'b1;
            // A zero-byte remainder cannot be encoded, so it is sent as a full errored beat.
            out_info.bytesvld = (trim == '0) ? 8'(DATA_BYTES) : 8'(trim);
            keep_n            = 8'(trim);
        end
    end

    assign byte_mask   = fn_mask_bytesvld_n(keep_n, DATA_BYTES);
    assign unused_mask = ^byte_mask;

    // Zero every byte past the kept count; byte 0 sits in the MSBs.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (byte_mask[i]) begin
                out_data[(DATA_BYTES-1-i)*8 +: 8] = s_tdata[(DATA_BYTES-1-i)*8 +: 8];
            end
        end
    end

    ptp_bridge_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (in_hs && emit),
        .s_ready_o (buf_ready),
        .s_data_i  ({over_evt, out_info, out_data}),
        .m_valid_o (m_tvalid),
        .m_ready_i (m_tready),
        .m_data_o  (buf_out)
    );

    assign {m_terr, m_tuser, m_tdata} = buf_out;
    assign pkt_evt = m_tvalid && m_tready && m_tuser[SEG_EOP_BIT];

    // Saturating counters; a clear beats a coincident event.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        over_cnt_d = over_cnt_q;
        ferr_cnt_d = ferr_cnt_q;
        if (cnt_clr) begin
            pkt_cnt_d  = '0;
            over_cnt_d = '0;
            ferr_cnt_d = '0;
        end else begin
            if (pkt_evt && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            if (over_evt && over_cnt_q != '1) over_cnt_d = over_cnt_q + CNT_WIDTH'(1);
            if (ferr_evt && ferr_cnt_q != '1) ferr_cnt_d = ferr_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            over_cnt_q <= '0;
            ferr_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            over_cnt_q <= over_cnt_d;
            ferr_cnt_q <= ferr_cnt_d;
        end
    end

    assign pkt_cnt         = pkt_cnt_q;
    assign oversize_cnt    = over_cnt_q;
    assign framing_err_cnt = ferr_cnt_q;

endmodule

// File: tb/tb_ptp_bridge_seg_len_guard.sv
module tb_ptp_bridge_seg_len_guard;
    import ptp_bridge_pkg::*;

    localparam int DB = 64;
    localparam int DW = DB * 8;
    localparam int UW = SEGMENT_INFO_WIDTH;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          terr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_terr;
    logic          cnt_clr;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] oversize_cnt;
    logic [CW-1:0] framing_err_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: 30% random, 2: stalled

    ptp_bridge_seg_len_guard #(
        .DATA_BYTES    (DB),
        .MAX_PKT_BYTES (9216),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tdata         (s_tdata),
        .s_tuser         (s_tuser),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tdata         (m_tdata),
        .m_tuser         (m_tuser),
        .m_terr          (m_terr),
        .cnt_clr         (cnt_clr),
        .pkt_cnt         (pkt_cnt),
        .oversize_cnt    (oversize_cnt),
        .framing_err_cnt (framing_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 99) < 30);
            default: m_tready = 1'b0;
        endcase
    end

    function automatic logic [UW-1:0] mk_user(input logic sop, input logic eop,
                                              input logic [7:0] bv);
        segment_info_s u;
        u.sop      = sop;
        u.eop      = eop;
        u.bytesvld = bv;
        u.src_port = 8'h3c;
        u.dst_port = 8'h5a;
        return u;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] keep_bytes(input logic [DW-1:0] d, input int n);
        logic [DW-1:0] r;
        r = d;
        for (int i = n; i < DB; i++) r[(DB-1-i)*8 +: 8] = 8'h00;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat was accepted.
    task automatic drive_beat(input logic sop, input logic eop, input logic [7:0] bv,
                              input logic [DW-1:0] d);
        int n;
        n        = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = mk_user(sop, eop, bv);
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $error("FAIL accept_timeout: observed s_tready=0 for %0d cycles expected 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic pass_beat(input logic sop, input logic eop, input logic [7:0] bv,
                             input logic [DW-1:0] d, input int keep);
        exp_t e;
        e.data = keep_bytes(d, keep);
        e.user = mk_user(sop, eop, bv);
        e.terr = 1'b0;
        exp_q.push_back(e);
        drive_beat(sop, eop, bv, d);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || m_tvalid) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                checks++;
                errors++;
                $error("FAIL drain_timeout: observed %0d pending beats expected 0", exp_q.size());
                break;
            end
        end
        sync();
    endtask

    // Output monitor: scoreboard compare plus hold-under-backpressure check.
    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_data;
    logic [UW-1:0] hold_user;
    int            out_idx = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                assert (m_tvalid === 1'b1 && m_tdata === hold_data && m_tuser === hold_user)
                else begin
                    errors++;
                    $error("FAIL hold_stable: observed valid=%0b user=%0h expected valid=1 user=%0h",
                           m_tvalid, m_tuser, hold_user);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: observed beat user=%0h expected none", m_tuser);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (m_tdata === e.data) else begin
                        errors++;
                        $error("FAIL out_data beat %0d: observed %h expected %h",
                               out_idx, m_tdata, e.data);
                    end
                    checks++;
                    assert (m_tuser === e.user) else begin
                        errors++;
                        $error("FAIL out_user beat %0d: observed %h expected %h",
                               out_idx, m_tuser, e.user);
                    end
                    checks++;
                    assert (m_terr === e.terr) else begin
                        errors++;
                        $error("FAIL out_terr beat %0d: observed %0b expected %0b",
                               out_idx, m_terr, e.terr);
                    end
                end
                out_idx++;
            end
            stall_q   = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_user = m_tuser;
        end
    end

    initial begin
        exp_t          e;
        logic [DW-1:0] d;
        logic [7:0]    bv;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        cnt_clr  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_ferr_cnt", 32'(framing_err_cnt), 0);
        sync();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("s_tready_after_rst", 32'(s_tready), 1);
        sync();

        // 3-beat packet, last bytesvld=10; non-eop bytesvld ignored
        pass_beat(1'b1, 1'b0, 8'd0, rand_data(), 64);
        chk("latency_1", 32'(m_tvalid), 1);
        pass_beat(1'b0, 1'b0, 8'd5, rand_data(), 64);
        pass_beat(1'b0, 1'b1, 8'd10, rand_data(), 10);
        wait_drain();
        chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
        chk("t1_oversize", 32'(oversize_cnt), 0);
        chk("t1_ferr", 32'(framing_err_cnt), 0);

        // Exactly 9216 bytes: 144 full beats
        for (int b = 0; b < 144; b++) pass_beat(b == 0, b == 143, 8'd0, rand_data(), 64);
        wait_drain();
        chk("t2_pkt_cnt", 32'(pkt_cnt), 2);
        chk("t2_oversize", 32'(oversize_cnt), 0);

        // 9300 bytes: beat 145 truncated with zero remainder, beat 146 dropped
        for (int b = 0; b < 146; b++) begin
            d = rand_data();
            if (b < 144) begin
                pass_beat(b == 0, 1'b0, 8'd0, d, 64);
            end else if (b == 144) begin
                e.data = '0;
                e.user = mk_user(1'b0, 1'b1, 8'd64);
                e.terr = 1'b1;
                exp_q.push_back(e);
                drive_beat(1'b0, 1'b0, 8'd0, d);
            end else begin
                drive_beat(1'b0, 1'b1, 8'd20, d);
            end
        end
        pass_beat(1'b1, 1'b0, 8'd0, rand_data(), 64);
        pass_beat(1'b0, 1'b1, 8'd33, rand_data(), 33);
        wait_drain();
        chk("t3_oversize", 32'(oversize_cnt), 1);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 4);
        chk("t3_ferr", 32'(framing_err_cnt), 0);

        // Missing eop: 100-beat fragment then a fresh 100-beat packet (must not truncate)
        for (int b = 0; b < 100; b++) pass_beat(b == 0, 1'b0, 8'd0, rand_data(), 64);
        for (int b = 0; b < 100; b++) begin
            pass_beat(b == 0, b == 99, (b == 99) ? 8'd7 : 8'd0, rand_data(), (b == 99) ? 7 : 64);
        end
        wait_drain();
        chk("t4_ferr_a", 32'(framing_err_cnt), 1);
        chk("t4_oversize", 32'(oversize_cnt), 1);
        drive_beat(1'b0, 1'b1, 8'd5, rand_data());
        drive_beat(1'b0, 1'b0, 8'd0, rand_data());
        drive_beat(1'b0, 1'b0, 8'd0, rand_data());
        pass_beat(1'b1, 1'b1, 8'd12, rand_data(), 12);
        wait_drain();
        chk("t4_ferr_b", 32'(framing_err_cnt), 4);
        chk("t4_pkt_cnt", 32'(pkt_cnt), 6);

        // Back-to-back single-beat packets under 30% ready
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            bv = 8'($urandom_range(1, 64));
            pass_beat(1'b1, 1'b1, bv, rand_data(), int'(bv));
        end
        wait_drain();
        rdy_mode = 0;
        sync();
        chk("t5_pkt_cnt", 32'(pkt_cnt), 46);

        // Clear, saturation, clear coincident with an event
        cnt_clr = 1'b1;
        sync();
        cnt_clr = 1'b0;
        chk("clr_pkt", 32'(pkt_cnt), 0);
        chk("clr_over", 32'(oversize_cnt), 0);
        chk("clr_ferr", 32'(framing_err_cnt), 0);
        for (int p = 0; p < 260; p++) pass_beat(1'b1, 1'b1, 8'd64, rand_data(), 64);
        wait_drain();
        chk("sat_pkt_cnt", 32'(pkt_cnt), 255);
        cnt_clr = 1'b1;
        drive_beat(1'b0, 1'b1, 8'd0, rand_data());
        cnt_clr = 1'b0;
        chk("clr_vs_evt_ferr", 32'(framing_err_cnt), 0);
        chk("clr_vs_evt_pkt", 32'(pkt_cnt), 0);

        // Reset mid-packet with both buffer entries occupied
        rdy_mode = 2;
        sync();
        sync();
        drive_beat(1'b1, 1'b0, 8'd0, rand_data());
        drive_beat(1'b0, 1'b0, 8'd0, rand_data());
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_tvalid", 32'(m_tvalid), 0);
        chk("midrst_s_tready", 32'(s_tready), 0);
        sync();
        rst      = 1'b0;
        rdy_mode = 0;
        sync();
        sync();
        drive_beat(1'b0, 1'b1, 8'd0, rand_data());
        pass_beat(1'b1, 1'b1, 8'd3, rand_data(), 3);
        wait_drain();
        chk("midrst_ferr", 32'(framing_err_cnt), 1);
        chk("midrst_pkt_cnt", 32'(pkt_cnt), 1);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
